// File: rtl/tff_counter_if.sv
// tff_counter_if: control/status bundle for tff_counter.
//   en, mode, t, d, clr_ovf : requests driven by the master
//   q, tc, ovf              : registered status returned by the slave (the counter)
// clk and rst are not part of the bundle; they stay plain ports on the counter.
interface tff_counter_if #(
    parameter int unsigned WIDTH = 8
);
    logic             en;
    logic [1:0]       mode;
    logic [WIDTH-1:0] t;
    logic [WIDTH-1:0] d;
    logic             clr_ovf;
    logic [WIDTH-1:0] q;
    logic             tc;
    logic             ovf;

    modport master (
        output en, mode, t, d, clr_ovf,
        input  q, tc, ovf
    );

    modport slave (
        input  en, mode, t, d, clr_ovf,
        output q, tc, ovf
    );
endinterface

// File: rtl/tff_counter.sv
// tff_counter: WIDTH-bit toggle / up / down / load register built from T flip-flops.
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset (q=RST_VAL, tc=0, ovf=0)
//   bus  tff_counter_if.slave:
//        en      operation enable (0 holds q)
//        mode    00 toggle by t, 01 count up, 10 count down, 11 load d
//        t, d    toggle mask / parallel load data
//        clr_ovf clears the sticky overflow flag (a same-cycle terminal event wins)
//        q       register value
//        tc      one-cycle registered terminal-count flag
//        ovf     sticky registered overflow/underflow flag
// SATURATE=0 wraps at the terminal value, SATURATE=1 holds there.
module tff_counter #(
    parameter int unsigned          WIDTH    = 8,
    parameter bit                   SATURATE = 1'b0,
    parameter logic [WIDTH-1:0]     RST_VAL  = '0
) (
    input  logic         clk,
    input  logic         rst,
    tff_counter_if.slave bus
);
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             tc_q, ovf_q, ovf_d;
    logic [WIDTH-1:0] up_tgl, dn_tgl;
    logic             all_ones, all_zero;
    logic             term;

    assign all_ones = &cnt_q;
    assign all_zero = ~|cnt_q;

    // Toggle enables of a synchronous T-FF counter: bit i flips when every lower bit
    // is 1 (up) or 0 (down). Bit 0 always flips.
    always_comb begin
        logic up_c;
        logic dn_c;
        up_c = 1'b1;
        dn_c = 1'b1;
        for (int i = 0; i < WIDTH; i++) begin
            up_tgl[i] = up_c;
            dn_tgl[i] = dn_c;
            up_c = up_c & cnt_q[i];
            dn_c = dn_c & ~cnt_q[i];
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        term  = 1'b0;
        if (bus.en) begin
            case (bus.mode)
                2'b00: cnt_d = cnt_q ^ bus.t;
                2'b01: begin
                    term = all_ones;
                    // At all-ones the toggle mask is all ones too, so wrapping to 0 is free.
                    if (!(term && SATURATE)) cnt_d = cnt_q ^ up_tgl;
                end
                2'b10: begin
                    term = all_zero;
                    if (!(term && SATURATE)) cnt_d = cnt_q ^ dn_tgl;
                end
                default: cnt_d = bus.d;
            endcase
        end
    end

    // Set beats clear when both occur in the same cycle.
    assign ovf_d = term | (ovf_q & ~bus.clr_ovf);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= RST_VAL;
            tc_q  <= 1'b0;
            ovf_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            tc_q  <= term;
            ovf_q <= ovf_d;
        end
    end

    assign bus.q   = cnt_q;
    assign bus.tc  = tc_q;
    assign bus.ovf = ovf_q;
endmodule
